cpu6_bus_target: RTL and testbench

- Bus responder on the far side of the CPU6 memory bus.
- Decodes `addressBus`, returns registered read data on `dataInBus`, and commits writes strobed by `writeEnBus`.
- Contains a RAM region and a memory-mapped MUX console port: status/data registers, a TX FIFO with a valid/ready handshake to a UART, and a one-entry RX holding register.
- Sits between CPU6 and the board-level serial link in the top-level system model.

---
 rtl/cpu6_bus_target.sv | 149 ++++++++++++++
 tb/tb_cpu6_bus_target.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu6_bus_target.sv
// CPU6 bus responder: RAM plus a memory-mapped MUX console (status, TX FIFO, RX holding register).
// Define CPU6_MUX_LOOPBACK_EN to feed the TX FIFO head straight into the RX holding register.
module cpu6_bus_target #(
    parameter int unsigned RAM_ADDR_BITS = 12,
    parameter int unsigned TX_DEPTH      = 4,
    parameter logic [15:0] MUX_BASE      = 16'hF200
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] addressBus,
    input  logic [7:0]  dataOutBus,
    input  logic        writeEnBus,
    output logic [7:0]  dataInBus,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid
);

    localparam int unsigned     RamSize = 32'd1 << RAM_ADDR_BITS;
    localparam int unsigned     PtrW    = $clog2(TX_DEPTH);
    localparam int unsigned     CntW    = PtrW + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(TX_DEPTH);

    logic [7:0]      r_ram [RamSize];
    logic [7:0]      r_fifo [TX_DEPTH];
    logic [PtrW-1:0] r_rd_ptr;
    logic [PtrW-1:0] r_wr_ptr;
    logic [CntW-1:0] r_count;
    logic [7:0]      r_rd_data;
    logic [7:0]      r_rx_hold;
    logic            r_rx_full;
    logic            r_overrun;
    logic            r_tx_drop;

    logic                     w_is_ram;
    logic                     w_is_stat;
    logic                     w_is_data;
    logic [RAM_ADDR_BITS-1:0] w_ram_idx;
    logic [7:0]               w_stat;
    logic [7:0]               w_rd_next;
    logic                     w_tx_empty;
    logic                     w_tx_full;
    logic                     w_push_req;
    logic                     w_push;
    logic                     w_drop;
    logic                     w_pop;
    logic                     w_wr_stat;
    logic                     w_rx_clr;
    logic                     w_ovr_clr;
    logic                     w_drop_clr;
    logic                     w_rx_in_valid;
    logic [7:0]               w_rx_in_data;
    logic                     w_rx_full_kept;
    logic                     w_rx_capture;
    logic                     w_overrun_set;

    assign w_is_ram  = 32'(addressBus) < RamSize;
    assign w_is_stat = addressBus == MUX_BASE;
    assign w_is_data = addressBus == MUX_BASE + 16'd1;
    assign w_ram_idx = addressBus[RAM_ADDR_BITS-1:0];

    assign w_tx_empty = r_count == '0;
    assign w_tx_full  = r_count == CntFull;
    assign w_stat     = {3'b000, r_tx_drop, w_tx_empty, r_overrun, ~w_tx_full, r_rx_full};

    always_comb begin
        w_rd_next = 8'hFF;
        if (w_is_ram) begin
            w_rd_next = r_ram[w_ram_idx];
        end else if (w_is_stat) begin
            w_rd_next = w_stat;
        end else if (w_is_data) begin
            w_rd_next = r_rx_hold;
        end
    end

    // Fullness is sampled before any same-edge pop, so a pop never makes room for a push.
    assign w_push_req = writeEnBus & w_is_data;
    assign w_push     = w_push_req & ~w_tx_full;
    assign w_drop     = w_push_req & w_tx_full;

    assign w_wr_stat  = writeEnBus & w_is_stat;
    assign w_rx_clr   = w_wr_stat & dataOutBus[0];
    assign w_ovr_clr  = w_wr_stat & dataOutBus[2];
    assign w_drop_clr = w_wr_stat & dataOutBus[4];

`ifdef CPU6_MUX_LOOPBACK_EN
    logic w_unused_ext;
    assign w_unused_ext  = ^{tx_ready, rx_data, rx_valid};
    assign w_pop         = ~w_tx_empty & ~r_rx_full;
    assign w_rx_in_valid = w_pop;
    assign w_rx_in_data  = r_fifo[r_rd_ptr];
    assign tx_valid      = 1'b0;
`else
    assign w_pop         = ~w_tx_empty & tx_ready;
    assign w_rx_in_valid = rx_valid;
    assign w_rx_in_data  = rx_data;
    assign tx_valid      = ~w_tx_empty;
`endif

    // A CPU clear of rx_full takes effect before a same-edge incoming byte is considered.
    assign w_rx_full_kept = r_rx_full & ~w_rx_clr;
    assign w_rx_capture   = w_rx_in_valid & ~w_rx_full_kept;
    assign w_overrun_set  = w_rx_in_valid & w_rx_full_kept;

    assign tx_data   = r_fifo[r_rd_ptr];
    assign dataInBus = r_rd_data;

    always_ff @(posedge clock) begin
        if (writeEnBus && w_is_ram) begin
            r_ram[w_ram_idx] <= dataOutBus;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TX_DEPTH; i++) begin
                r_fifo[i] <= 8'h00;
            end
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_rd_data <= 8'h00;
            r_rx_hold <= 8'h00;
            r_rx_full <= 1'b0;
            r_overrun <= 1'b0;
            r_tx_drop <= 1'b0;
        end else begin
            r_rd_data <= w_rd_next;
            if (w_push) begin
                r_fifo[r_wr_ptr] <= dataOutBus;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count   <= r_count + CntW'(w_push) - CntW'(w_pop);
            r_rx_full <= w_rx_full_kept | w_rx_capture;
            if (w_rx_capture) begin
                r_rx_hold <= w_rx_in_data;
            end
            r_overrun <= (r_overrun & ~w_ovr_clr) | w_overrun_set;
            r_tx_drop <= (r_tx_drop & ~w_drop_clr) | w_drop;
        end
    end

endmodule

// File: tb/tb_cpu6_bus_target.sv
// Self-checking bench for cpu6_bus_target: directed vector table, reset cases and a
// randomized run against a queue-based reference model of the bus target.
module tb_cpu6_bus_target;

    localparam int unsigned RAM_SIZE = 4096;
    localparam int unsigned DEPTH    = 4;
    localparam logic [15:0] STAT     = 16'hF200;
    localparam logic [15:0] DATA     = 16'hF201;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] addressBus;
    logic [7:0]  dataOutBus;
    logic        writeEnBus;
    logic [7:0]  dataInBus;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;

    int n_checks = 0;
    int n_fail   = 0;

    cpu6_bus_target dut (
        .clock      (clock),
        .reset      (reset),
        .addressBus (addressBus),
        .dataOutBus (dataOutBus),
        .writeEnBus (writeEnBus),
        .dataInBus  (dataInBus),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid)
    );

    always #5 clock = ~clock;

    // Reference model state
    logic [7:0] m_ram [int];
    logic [7:0] m_q [$];
    logic       m_rx_full;
    logic       m_overrun;
    logic       m_tx_drop;
    logic [7:0] m_rx_hold;
    logic [7:0] m_exp_rd;
    logic       m_exp_known;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  wd;
        logic        we;
        logic        rdy;
        logic [7:0]  rxd;
        logic        rv;
        logic        chk_rd;
        logic [7:0]  exp_rd;
        logic        exp_valid;
        logic        chk_tx;
        logic [7:0]  exp_tx;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(input logic [15:0] addr, input logic [7:0] wd, input logic we,
                                input logic rdy, input logic [7:0] rxd, input logic rv,
                                input logic chk_rd, input logic [7:0] exp_rd,
                                input logic exp_valid, input logic chk_tx,
                                input logic [7:0] exp_tx);
        vec_t v;
        v.addr = addr; v.wd = wd; v.we = we; v.rdy = rdy; v.rxd = rxd; v.rv = rv;
        v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_valid = exp_valid;
        v.chk_tx = chk_tx; v.exp_tx = exp_tx;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_rx_full = 1'b0;
        m_overrun = 1'b0;
        m_tx_drop = 1'b0;
        m_rx_hold = 8'h00;
    endtask

    // One bus cycle of the target, described as: read the old state, then apply the edge.
    task automatic model_step(input logic [15:0] a, input logic [7:0] wd, input logic we,
                              input logic rdy, input logic [7:0] rxd, input logic rv);
        bit was_full;
        bit clr_rx;
        bit full_eff;
        m_exp_known = 1'b1;
        if (32'(a) < RAM_SIZE) begin
            if (m_ram.exists(int'(a))) m_exp_rd = m_ram[int'(a)];
            else m_exp_known = 1'b0;
        end else if (a == STAT) begin
            m_exp_rd = {3'b000, m_tx_drop, m_q.size() == 0, m_overrun, m_q.size() < DEPTH,
                        m_rx_full};
        end else if (a == DATA) begin
            m_exp_rd = m_rx_hold;
        end else begin
            m_exp_rd = 8'hFF;
        end
        was_full = m_q.size() == DEPTH;
        clr_rx   = 1'b0;
        if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
        if (we) begin
            if (32'(a) < RAM_SIZE) begin
                m_ram[int'(a)] = wd;
            end else if (a == DATA) begin
                if (!was_full) m_q.push_back(wd);
                else m_tx_drop = 1'b1;
            end else if (a == STAT) begin
                clr_rx = wd[0];
                if (wd[2]) m_overrun = 1'b0;
                if (wd[4]) m_tx_drop = 1'b0;
            end
        end
        full_eff = m_rx_full && !clr_rx;
        if (rv) begin
            if (!full_eff) begin
                m_rx_hold = rxd;
                m_rx_full = 1'b1;
            end else begin
                m_rx_full = 1'b1;
                m_overrun = 1'b1;
            end
        end else begin
            m_rx_full = full_eff;
        end
    endtask

    task automatic cyc(input logic [15:0] a, input logic [7:0] wd, input logic we,
                       input logic rdy, input logic [7:0] rxd, input logic rv);
        addressBus = a;
        dataOutBus = wd;
        writeEnBus = we;
        tx_ready   = rdy;
        rx_data    = rxd;
        rx_valid   = rv;
        model_step(a, wd, we, rdy, rxd, rv);
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        cyc(16'h8000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        logic [15:0] unm [4];
        logic [15:0] a;
        logic [7:0]  wd;
        logic        we;
        logic        rdy;
        logic        rv;
        unm[0] = 16'h1000; unm[1] = 16'h8000; unm[2] = 16'hF1FF; unm[3] = 16'hF202;

        reset = 1'b1; addressBus = 16'h0; dataOutBus = 8'h0; writeEnBus = 1'b0;
        tx_ready = 1'b0; rx_data = 8'h0; rx_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("reset dataInBus", dataInBus, 8'h00);
        check("reset tx_valid", {7'b0, tx_valid}, 8'h00);
        check("reset tx_data", tx_data, 8'h00);
        reset = 1'b0;

`ifdef CPU6_MUX_LOOPBACK_EN
        cyc(DATA, 8'h77, 1'b1, 1'b1, 8'h00, 1'b0);
        check("lb push tx_valid", {7'b0, tx_valid}, 8'h00);
        cyc(STAT, 8'h00, 1'b0, 1'b1, 8'h55, 1'b1);
        check("lb stat1", dataInBus, 8'h02);
        check("lb tx_valid1", {7'b0, tx_valid}, 8'h00);
        cyc(STAT, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        check("lb stat2", dataInBus, 8'h0B);
        cyc(DATA, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        check("lb data", dataInBus, 8'h77);
        check("lb tx_valid2", {7'b0, tx_valid}, 8'h00);
`else
        // addr, wd, we, rdy, rxd, rv, chk_rd, exp_rd, exp_valid, chk_tx, exp_tx
        vecs.push_back(mk(STAT,     8'h00, 0, 0, 8'h00, 0, 1, 8'h0A, 0, 0, 8'h00));
        vecs.push_back(mk(16'h0123, 8'h5A, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00));
        vecs.push_back(mk(16'h0123, 8'h00, 0, 0, 8'h00, 0, 1, 8'h5A, 0, 0, 8'h00));
        vecs.push_back(mk(16'h8000, 8'h00, 0, 0, 8'h00, 0, 1, 8'hFF, 0, 0, 8'h00));
        vecs.push_back(mk(16'h0123, 8'hA5, 1, 0, 8'h00, 0, 1, 8'h5A, 0, 0, 8'h00));
        vecs.push_back(mk(16'h0123, 8'h00, 0, 0, 8'h00, 0, 1, 8'hA5, 0, 0, 8'h00));
        vecs.push_back(mk(16'h0FFF, 8'hC3, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00));
        vecs.push_back(mk(16'h0FFF, 8'h00, 0, 0, 8'h00, 0, 1, 8'hC3, 0, 0, 8'h00));
        vecs.push_back(mk(16'h1000, 8'h00, 0, 0, 8'h00, 0, 1, 8'hFF, 0, 0, 8'h00));
        vecs.push_back(mk(16'hF202, 8'h00, 0, 0, 8'h00, 0, 1, 8'hFF, 0, 0, 8'h00));
        vecs.push_back(mk(16'hF1FF, 8'h00, 0, 0, 8'h00, 0, 1, 8'hFF, 0, 0, 8'h00));
        // TX fill past full, then drain in order
        vecs.push_back(mk(DATA,     8'h41, 1, 0, 8'h00, 0, 1, 8'h00, 1, 1, 8'h41));
        vecs.push_back(mk(DATA,     8'h42, 1, 0, 8'h00, 0, 1, 8'h00, 1, 1, 8'h41));
        vecs.push_back(mk(DATA,     8'h43, 1, 0, 8'h00, 0, 1, 8'h00, 1, 1, 8'h41));
        vecs.push_back(mk(DATA,     8'h44, 1, 0, 8'h00, 0, 1, 8'h00, 1, 1, 8'h41));
        vecs.push_back(mk(DATA,     8'h45, 1, 0, 8'h00, 0, 1, 8'h00, 1, 1, 8'h41));
        vecs.push_back(mk(STAT,     8'h00, 0, 0, 8'h00, 0, 1, 8'h10, 1, 1, 8'h41));
        vecs.push_back(mk(STAT,     8'h00, 0, 1, 8'h00, 0, 1, 8'h10, 1, 1, 8'h42));
        vecs.push_back(mk(STAT,     8'h00, 0, 1, 8'h00, 0, 1, 8'h12, 1, 1, 8'h43));
        vecs.push_back(mk(STAT,     8'h00, 0, 1, 8'h00, 0, 1, 8'h12, 1, 1, 8'h44));
        vecs.push_back(mk(STAT,     8'h00, 0, 1, 8'h00, 0, 1, 8'h12, 0, 0, 8'h00));
        vecs.push_back(mk(STAT,     8'h10, 1, 0, 8'h00, 0, 1, 8'h1A, 0, 0, 8'h00));
        vecs.push_back(mk(STAT,     8'h00, 0, 0, 8'h00, 0, 1, 8'h0A, 0, 0, 8'h00));
        // RX capture, overrun, clear-with-capture, set-wins
        vecs.push_back(mk(STAT,     8'h00, 0, 0, 8'h37, 1, 1, 8'h0A, 0, 0, 8'h00));
        vecs.push_back(mk(STAT,     8'h00, 0, 0, 8'h00, 0, 1, 8'h0B, 0, 0, 8'h00));
        vecs.push_back(mk(DATA,     8'h00, 0, 0, 8'h00, 0, 1, 8'h37, 0, 0, 8'h00));
        vecs.push_back(mk(DATA,     8'h00, 0, 0, 8'h38, 1, 1, 8'h37, 0, 0, 8'h00));
        vecs.push_back(mk(STAT,     8'h00, 0, 0, 8'h00, 0, 1, 8'h0F, 0, 0, 8'h00));
        vecs.push_back(mk(DATA,     8'h00, 0, 0, 8'h00, 0, 1, 8'h37, 0, 0, 8'h00));
        vecs.push_back(mk(STAT,     8'h05, 1, 0, 8'h39, 1, 1, 8'h0F, 0, 0, 8'h00));
        vecs.push_back(mk(DATA,     8'h00, 0, 0, 8'h00, 0, 1, 8'h39, 0, 0, 8'h00));
        vecs.push_back(mk(STAT,     8'h00, 0, 0, 8'h00, 0, 1, 8'h0B, 0, 0, 8'h00));
        vecs.push_back(mk(STAT,     8'h04, 1, 0, 8'h3A, 1, 1, 8'h0B, 0, 0, 8'h00));
        vecs.push_back(mk(STAT,     8'h00, 0, 0, 8'h00, 0, 1, 8'h0F, 0, 0, 8'h00));
        vecs.push_back(mk(STAT,     8'h05, 1, 0, 8'h00, 0, 1, 8'h0F, 0, 0, 8'h00));
        vecs.push_back(mk(STAT,     8'h00, 0, 0, 8'h00, 0, 1, 8'h0A, 0, 0, 8'h00));
        // Same-edge push and pop at count=2
        vecs.push_back(mk(DATA,     8'h51, 1, 0, 8'h00, 0, 1, 8'h39, 1, 1, 8'h51));
        vecs.push_back(mk(DATA,     8'h52, 1, 0, 8'h00, 0, 1, 8'h39, 1, 1, 8'h51));
        vecs.push_back(mk(DATA,     8'h60, 1, 1, 8'h00, 0, 1, 8'h39, 1, 1, 8'h52));
        vecs.push_back(mk(STAT,     8'h00, 0, 0, 8'h00, 0, 1, 8'h02, 1, 1, 8'h52));
        vecs.push_back(mk(STAT,     8'h00, 0, 1, 8'h00, 0, 1, 8'h02, 1, 1, 8'h60));
        vecs.push_back(mk(STAT,     8'h00, 0, 1, 8'h00, 0, 1, 8'h02, 0, 0, 8'h00));
        vecs.push_back(mk(STAT,     8'h00, 0, 0, 8'h00, 0, 1, 8'h0A, 0, 0, 8'h00));
        // Full FIFO with same-edge pop: push is still dropped
        vecs.push_back(mk(DATA,     8'h70, 1, 0, 8'h00, 0, 1, 8'h39, 1, 1, 8'h70));
        vecs.push_back(mk(DATA,     8'h71, 1, 0, 8'h00, 0, 1, 8'h39, 1, 1, 8'h70));
        vecs.push_back(mk(DATA,     8'h72, 1, 0, 8'h00, 0, 1, 8'h39, 1, 1, 8'h70));
        vecs.push_back(mk(DATA,     8'h73, 1, 0, 8'h00, 0, 1, 8'h39, 1, 1, 8'h70));
        vecs.push_back(mk(DATA,     8'h74, 1, 1, 8'h00, 0, 1, 8'h39, 1, 1, 8'h71));
        vecs.push_back(mk(STAT,     8'h00, 0, 0, 8'h00, 0, 1, 8'h12, 1, 1, 8'h71));
        vecs.push_back(mk(STAT,     8'h00, 0, 1, 8'h00, 0, 1, 8'h12, 1, 1, 8'h72));
        vecs.push_back(mk(STAT,     8'h00, 0, 1, 8'h00, 0, 1, 8'h12, 1, 1, 8'h73));
        vecs.push_back(mk(STAT,     8'h00, 0, 1, 8'h00, 0, 1, 8'h12, 0, 0, 8'h00));
        vecs.push_back(mk(STAT,     8'h10, 1, 0, 8'h00, 0, 1, 8'h1A, 0, 0, 8'h00));
        vecs.push_back(mk(STAT,     8'h00, 0, 0, 8'h00, 0, 1, 8'h0A, 0, 0, 8'h00));

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].addr, vecs[i].wd, vecs[i].we, vecs[i].rdy, vecs[i].rxd, vecs[i].rv);
            if (vecs[i].chk_rd) check($sformatf("vec%0d rd", i), dataInBus, vecs[i].exp_rd);
            check($sformatf("vec%0d tx_valid", i), {7'b0, tx_valid}, {7'b0, vecs[i].exp_valid});
            if (vecs[i].chk_tx) check($sformatf("vec%0d tx_data", i), tx_data, vecs[i].exp_tx);
        end

        // Randomized run against the model; seed a small RAM window first
        for (int i = 0; i < 16; i++) begin
            cyc(16'h0100 + 16'(i), 8'($urandom_range(0, 255)), 1'b1, 1'b0, 8'h00, 1'b0);
        end
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 9))
                3, 4:    a = STAT;
                5, 6:    a = DATA;
                7:       a = unm[$urandom_range(0, 3)];
                default: a = 16'h0100 + 16'($urandom_range(0, 15));
            endcase
            wd  = 8'($urandom_range(0, 255));
            we  = 1'($urandom_range(0, 1));
            rdy = $urandom_range(0, 2) == 0;
            rv  = $urandom_range(0, 3) == 0;
            cyc(a, wd, we, rdy, 8'($urandom_range(0, 255)), rv);
            if (m_exp_known) check($sformatf("rand%0d rd @%h", i, a), dataInBus, m_exp_rd);
            check($sformatf("rand%0d tx_valid", i), {7'b0, tx_valid},
                  {7'b0, m_q.size() != 0});
            if (m_q.size() != 0) check($sformatf("rand%0d tx_data", i), tx_data, m_q[0]);
        end

        // Asynchronous reset mid-operation: FIFO/RX state gone, RAM kept
        cyc(STAT, 8'h15, 1'b1, 1'b0, 8'h00, 1'b0);
        cyc(DATA, 8'hAB, 1'b1, 1'b0, 8'hCD, 1'b1);
        cyc(16'h8000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        check("pre-reset rd", dataInBus, 8'hFF);
        check("pre-reset tx_valid", {7'b0, tx_valid}, 8'h01);
        #2 reset = 1'b1;
        #1;
        check("async reset dataInBus", dataInBus, 8'h00);
        check("async reset tx_valid", {7'b0, tx_valid}, 8'h00);
        check("async reset tx_data", tx_data, 8'h00);
        @(posedge clock);
        #1 reset = 1'b0;
        model_reset();
        cyc(STAT, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        check("post-reset stat", dataInBus, 8'h0A);
        cyc(DATA, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        check("post-reset data", dataInBus, 8'h00);
        cyc(16'h0123, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        check("ram kept over reset", dataInBus, 8'hA5);
        idle();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
